exp_sp_arbiter_n: RTL and testbench
===================================

Name: exp_sp_arbiter_n

Overview:
- N-channel successor to the two-port exp/softplus sharing wrapper.
- Arbitrates NCH requesters onto one softplus_or_exp16 core. Each request carries its own mode bit. Simultaneous requests are legal and resolved round-robin.
- Each result is routed back to its originating channel through per-mode tag FIFOs, with valid/ready backpressure on the request side.
- Sits between the SSM lane controllers (dt softplus, dA exp) and the single shared nonlinearity core.

Parameters:
- DW, 16, data width (FP16).
- NCH, 4, number of requesting channels (>=2).
- TAG_DEPTH, 16, per-mode tag FIFO depth; caps in-flight requests per mode (power of 2).
- LAT_MUL, 1, passed to core.
- LAT_ADD, 1, passed to core.
- LAT_DIV, 1, passed to core.
- LAT_EXP, 6+3*LAT_MUL+3*LAT_ADD, passed to core.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high; core receives ~rst.
- req_v  in  NCH  per-channel request valid.
- req_mode  in  NCH  per-channel mode: 1=softplus, 0=exp.
- req_x  in  NCH*DW  per-channel operand, channel c at [c*DW +: DW].
- req_rdy  out  NCH  per-channel accept (one-hot or zero).
- sp_rsp_v  out  NCH  softplus result valid, one-hot or zero.
- sp_y  out  DW  softplus result, broadcast.
- exp_rsp_v  out  NCH  exp result valid, one-hot or zero.
- exp_y  out  DW  exp result, broadcast.
- busy  out  1  any tag FIFO non-empty or issue register valid.
- err_underflow  out  1  sticky: core produced a result with its tag FIFO empty.

Behaviour:
- Eligibility: channel c is eligible when req_v[c]=1 and the tag FIFO for req_mode[c] is not full. Full is evaluated on the registered count; a same-cycle pop does not free a slot.
- Arbitration: round-robin pointer ptr (log2 NCH bits).
  - Grant g = first eligible index scanning ptr, ptr+1, ... wrapping modulo NCH.
  - req_rdy[g]=1 combinationally; all other req_rdy bits are 0. No eligible channel means no grant.
  - Transfer occurs when req_v & req_rdy. On transfer, ptr <= (g+1) mod NCH; otherwise ptr holds.
- Handshake: a requester holds req_v, req_mode and req_x stable until accepted. req_rdy may depend on req_v. A channel that is not eligible because its mode FIFO is full does not block other channels.
- Issue stage: on transfer, register core_vi=1, core_mode=req_mode[g], core_xi=req_x[g]. In the same cycle, push g into the sp FIFO (mode 1) or the exp FIFO (mode 0). With no transfer, core_vi=0 and core_xi/core_mode hold their previous values (no X injection).
- Throughput: one issue per cycle maximum.
- Latency: response appears 1 + core latency of that mode after the accept cycle. Order is preserved within a mode. The two modes may complete out of order relative to each other.
- Response routing:
  - Core valid_o_S pops the sp FIFO head h; sp_rsp_v[h]=1 and sp_y=y_o_S in the same cycle (combinational from FIFO head).
  - exp path is identical, using valid_o_e and the exp FIFO.
  - sp and exp responses may occur in the same cycle, to the same or different channels; both are delivered, one on each output bus.
- Simultaneous push and pop on one FIFO in one cycle: legal; count unchanged.
- Underflow: a core valid with its FIFO empty sets err_underflow (sticky until rst). The corresponding rsp_v stays 0 and the FIFO pointers are unchanged.
- No response-side backpressure: consumers must accept rsp_v pulses.
- Reset (synchronous, including mid-operation):
  - ptr=0, both FIFOs empty, issue register cleared, err_underflow=0.
  - All outputs 0: req_rdy, sp_rsp_v, exp_rsp_v, busy, sp_y, exp_y.
  - In-flight core work is discarded via core reset; no response is emitted for any request accepted before reset.
- Mode/result width: no arithmetic in this block; data passes unmodified through DW bits.

Test Plan:
- Single exp, channel 2, x=0x0000 -> req_rdy[2] the same cycle; exp_rsp_v=0100b and exp_y=0x3C00 exactly 1+core latency later; sp_rsp_v stays 0.
- Single softplus, channel 0, x=0x0000 -> sp_rsp_v=0001b and sp_y=0x398C (ln2) after 1+core softplus latency.
- All 4 channels assert every cycle with alternating modes, ptr=0 -> grants in order 0,1,2,3,0,... one per cycle; each channel receives exactly one response per accepted request, routed to the correct channel.
- Fill sp FIFO: 16 outstanding softplus requests with the core output stalled by long latency -> 17th sp requester sees req_rdy=0 while an exp requester on another channel is still granted; the sp requester is granted once the first sp result pops.
- Same-cycle completion: sp issued at cycle t, exp issued at t+k, with k chosen so both valids coincide -> sp_rsp_v and exp_rsp_v both one-hot in the same cycle with correct sp_y and exp_y.
- Assert rst with 5 requests in flight -> next cycle all outputs 0, busy=0; no rsp_v pulses afterwards; a new request then completes normally; err_underflow remains 0.

Source files
------------

// File: rtl/exp_sp_arbiter_n.sv
// exp_sp_arbiter_n
//   Shares one softplus_or_exp16 core between NCH requesters. Each request
//   carries its own mode bit (1 = softplus, 0 = exp). Requests are granted
//   round-robin, one per cycle. The originating channel index is pushed into
//   a per-mode tag FIFO at issue. When the core produces a result, the FIFO
//   head names the channel that receives it.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req_v[NCH]         per-channel request valid
//   req_mode[NCH]      per-channel mode, 1 = softplus, 0 = exp
//   req_x[NCH*DW]      per-channel operand, channel c at [c*DW +: DW]
//   req_rdy[NCH]       per-channel accept (one-hot or zero)
//   sp_rsp_v[NCH]      softplus result strobe (one-hot or zero), data on sp_y
//   exp_rsp_v[NCH]     exp result strobe (one-hot or zero), data on exp_y
//   busy               a tag FIFO is non-empty or the issue register is valid
//   err_underflow      sticky: the core returned a result with its tag FIFO empty

module exp_sp_arbiter_n #(
  parameter int DW        = 16,
  parameter int NCH       = 4,
  parameter int TAG_DEPTH = 16,
  parameter int LAT_MUL   = 1,
  parameter int LAT_ADD   = 1,
  parameter int LAT_DIV   = 1,
  parameter int LAT_EXP   = 6 + 3*LAT_MUL + 3*LAT_ADD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_v,
  input  logic [NCH-1:0]    req_mode,
  input  logic [NCH*DW-1:0] req_x,
  output logic [NCH-1:0]    req_rdy,
  output logic [NCH-1:0]    sp_rsp_v,
  output logic [DW-1:0]     sp_y,
  output logic [NCH-1:0]    exp_rsp_v,
  output logic [DW-1:0]     exp_y,
  output logic              busy,
  output logic              err_underflow
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  // Round-robin pointer and issue register
  logic [PW-1:0] ptr_reg;
  logic          core_vi_reg;
  logic          core_mode_reg;
  logic [DW-1:0] core_xi_reg;
  logic          err_reg;

  // Per-mode FIFO status; index 0 = exp, 1 = softplus (same as the mode bit)
  logic [1:0]      full;
  logic [1:0]      nonempty;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      underflow;
  logic [2*PW-1:0] head_flat;

  logic          core_v_s;
  logic          core_v_e;
  logic [DW-1:0] core_y_s;
  logic [DW-1:0] core_y_e;
  logic [1:0]    core_v;

  logic [NCH-1:0] elig;
  logic           grant_found;
  logic [PW-1:0]  grant_idx;
  logic           xfer;
  logic           sel_mode;
  logic [DW-1:0]  sel_x;

  assign core_v = {core_v_s, core_v_e};

  // Grant the first eligible channel at or after ptr, wrapping modulo NCH.
  // Fullness uses the registered count, so a pop in this cycle does not
  // make room until the next cycle.
  always_comb begin
    int idx;
    elig        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int c = 0; c < NCH; c++) begin
      elig[c] = req_v[c] & ~full[req_mode[c]];
    end
    for (int i = 0; i < NCH; i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!grant_found && elig[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(idx);
      end
    end
    if (rst) grant_found = 1'b0;
  end

  assign xfer     = grant_found;
  assign sel_mode = req_mode[grant_idx];
  assign sel_x    = req_x[grant_idx*DW +: DW];
  assign req_rdy  = grant_found ? (NCH'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= '0;
      core_vi_reg   <= 1'b0;
      core_mode_reg <= 1'b0;
      core_xi_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      core_vi_reg <= xfer;
      if (xfer) begin
        core_mode_reg <= sel_mode;
        core_xi_reg   <= sel_x;
        ptr_reg       <= (grant_idx == PW'(NCH-1)) ? '0 : grant_idx + 1'b1;
      end
      if (|underflow) err_reg <= 1'b1;
    end
  end

  // One tag FIFO per mode. The head is read combinationally so the response
  // strobe lands in the same cycle as the core valid.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tag_fifo
      logic [PW-1:0] mem [TAG_DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [CW-1:0] cnt_reg;

      assign full[gi]      = (cnt_reg == CW'(TAG_DEPTH));
      assign nonempty[gi]  = (cnt_reg != '0);
      assign push[gi]      = xfer & (sel_mode == 1'(gi));
      assign pop[gi]       = core_v[gi] & nonempty[gi] & ~rst;
      assign underflow[gi] = core_v[gi] & ~nonempty[gi] & ~rst;
      assign head_flat[gi*PW +: PW] = mem[rd_ptr_reg];

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
        end else begin
          if (push[gi]) begin
            mem[wr_ptr_reg] <= grant_idx;
            wr_ptr_reg      <= wr_ptr_reg + 1'b1;
          end
          if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({push[gi], pop[gi]})
            2'b10:   cnt_reg <= cnt_reg + 1'b1;
            2'b01:   cnt_reg <= cnt_reg - 1'b1;
            default: cnt_reg <= cnt_reg;
          endcase
        end
      end
    end
  endgenerate

  assign sp_rsp_v      = pop[1] ? (NCH'(1) << head_flat[PW +: PW]) : '0;
  assign exp_rsp_v     = pop[0] ? (NCH'(1) << head_flat[0 +: PW]) : '0;
  assign sp_y          = pop[1] ? core_y_s : '0;
  assign exp_y         = pop[0] ? core_y_e : '0;
  assign busy          = (|nonempty) | core_vi_reg;
  assign err_underflow = err_reg;

  softplus_or_exp16 #(
    .DW      (DW),
    .LAT_MUL (LAT_MUL),
    .LAT_ADD (LAT_ADD),
    .LAT_DIV (LAT_DIV),
    .LAT_EXP (LAT_EXP)
  ) u_core (
    .clk       (clk),
    .rst_n     (~rst),
    .valid_i   (core_vi_reg),
    .mode_i    (core_mode_reg),
    .x_i       (core_xi_reg),
    .valid_o_S (core_v_s),
    .y_o_S     (core_y_s),
    .valid_o_e (core_v_e),
    .y_o_e     (core_y_e)
  );
endmodule

// softplus_or_exp16
//   Behavioural stand-in for the shared nonlinearity core so the wrapper
//   elaborates on its own. Valid timing is exact: exp results appear LAT_EXP
//   cycles after valid_i, softplus results LAT_EXP + 2*LAT_ADD + LAT_MUL +
//   LAT_DIV cycles after valid_i. The data transform is x ^ f(0), which gives
//   exp(0) = 0x3C00 and softplus(0) = 0x398C exactly, and keeps every operand
//   distinguishable at the output.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   valid_i, mode_i, x_i  issue strobe, mode (1 = softplus), operand
//   valid_o_S, y_o_S      softplus result
//   valid_o_e, y_o_e      exp result
module softplus_or_exp16 #(
  parameter int DW      = 16,
  parameter int LAT_MUL = 1,
  parameter int LAT_ADD = 1,
  parameter int LAT_DIV = 1,
  parameter int LAT_EXP = 6 + 3*LAT_MUL + 3*LAT_ADD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic          mode_i,
  input  logic [DW-1:0] x_i,
  output logic          valid_o_S,
  output logic [DW-1:0] y_o_S,
  output logic          valid_o_e,
  output logic [DW-1:0] y_o_e
);
  localparam int LAT_SP = LAT_EXP + 2*LAT_ADD + LAT_MUL + LAT_DIV;
  localparam logic [DW-1:0] SP_K  = DW'(16'h398C);
  localparam logic [DW-1:0] EXP_K = DW'(16'h3C00);

  logic [LAT_SP-1:0]  sp_v_reg;
  logic [LAT_EXP-1:0] ex_v_reg;
  logic [DW-1:0]      sp_d_reg [LAT_SP];
  logic [DW-1:0]      ex_d_reg [LAT_EXP];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_v_reg <= '0;
      ex_v_reg <= '0;
    end else begin
      sp_v_reg <= {sp_v_reg[LAT_SP-2:0],  valid_i &  mode_i};
      ex_v_reg <= {ex_v_reg[LAT_EXP-2:0], valid_i & ~mode_i};
    end
  end

  always_ff @(posedge clk) begin
    sp_d_reg[0] <= x_i ^ SP_K;
    ex_d_reg[0] <= x_i ^ EXP_K;
    for (int i = 1; i < LAT_SP; i++)  sp_d_reg[i] <= sp_d_reg[i-1];
    for (int i = 1; i < LAT_EXP; i++) ex_d_reg[i] <= ex_d_reg[i-1];
  end

  assign valid_o_S = sp_v_reg[LAT_SP-1];
  assign y_o_S     = sp_d_reg[LAT_SP-1];
  assign valid_o_e = ex_v_reg[LAT_EXP-1];
  assign y_o_e     = ex_d_reg[LAT_EXP-1];
endmodule

// File: tb/tb_exp_sp_arbiter_n.sv
// Directed bench for exp_sp_arbiter_n (default parameters).
// Core latencies: exp = 6+3*1+3*1 = 12, softplus = 12+2*1+1+1 = 16.
// Responses land 1 + latency cycles after the accept cycle.
module tb_exp_sp_arbiter_n;
  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int LE  = 12;
  localparam int LS  = 16;
  localparam logic [15:0] KE = 16'h3C00;
  localparam logic [15:0] KS = 16'h398C;

  typedef struct {
    int          cyc;
    int          ch;
    logic [15:0] y;
  } rsp_t;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    req_v;
  logic [NCH-1:0]    req_mode;
  logic [NCH*DW-1:0] req_x;
  logic [NCH-1:0]    req_rdy;
  logic [NCH-1:0]    sp_rsp_v;
  logic [DW-1:0]     sp_y;
  logic [NCH-1:0]    exp_rsp_v;
  logic [DW-1:0]     exp_y;
  logic              busy;
  logic              err_underflow;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  rsp_t got_s[$];
  rsp_t got_e[$];
  rsp_t exp_s[$];
  rsp_t exp_e[$];

  exp_sp_arbiter_n dut (
    .clk           (clk),
    .rst           (rst),
    .req_v         (req_v),
    .req_mode      (req_mode),
    .req_x         (req_x),
    .req_rdy       (req_rdy),
    .sp_rsp_v      (sp_rsp_v),
    .sp_y          (sp_y),
    .exp_rsp_v     (exp_rsp_v),
    .exp_y         (exp_y),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every response strobe bit as a separate record.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (sp_rsp_v[c])  got_s.push_back('{cyc, c, sp_y});
      if (exp_rsp_v[c]) got_e.push_back('{cyc, c, exp_y});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int c, input logic m, input logic [15:0] x);
    req_v[c]             = 1'b1;
    req_mode[c]          = m;
    req_x[c*DW +: DW]    = x;
  endtask

  task automatic expect_rsp(input logic m, input int c, input int acc, input logic [15:0] x);
    rsp_t r;
    r.ch = c;
    if (m) begin
      r.cyc = acc + 1 + LS;
      r.y   = x ^ KS;
      exp_s.push_back(r);
    end else begin
      r.cyc = acc + 1 + LE;
      r.y   = x ^ KE;
      exp_e.push_back(r);
    end
  endtask

  task automatic check_logs(input string ph);
    chk({ph, "_n_sp_rsp"},  got_s.size(), exp_s.size());
    chk({ph, "_n_exp_rsp"}, got_e.size(), exp_e.size());
    for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
      chk({ph, "_sp_cycle"}, got_s[i].cyc, exp_s[i].cyc);
      chk({ph, "_sp_chan"},  got_s[i].ch,  exp_s[i].ch);
      chk({ph, "_sp_y"},     got_s[i].y,   exp_s[i].y);
    end
    for (int i = 0; i < exp_e.size() && i < got_e.size(); i++) begin
      chk({ph, "_exp_cycle"}, got_e[i].cyc, exp_e[i].cyc);
      chk({ph, "_exp_chan"},  got_e[i].ch,  exp_e[i].ch);
      chk({ph, "_exp_y"},     got_e[i].y,   exp_e[i].y);
    end
    got_s.delete();
    got_e.delete();
    exp_s.delete();
    exp_e.delete();
  endtask

  initial begin
    int a0;
    int n[NCH];
    int g;
    for (int c = 0; c < NCH; c++) n[c] = 0;

    // Reset: requests pending during reset are not accepted
    rst = 1'b1; req_v = '0; req_mode = '0; req_x = '0;
    repeat (2) next_cycle();
    req_v = 4'b1111;
    mid();
    chk("rst_rdy_held_in_reset", req_rdy, 4'b0000);
    next_cycle();
    req_v = '0;
    rst   = 1'b0;
    mid();
    chk("rst_req_rdy",   req_rdy,       4'b0000);
    chk("rst_sp_rsp_v",  sp_rsp_v,      4'b0000);
    chk("rst_exp_rsp_v", exp_rsp_v,     4'b0000);
    chk("rst_sp_y",      sp_y,          16'h0000);
    chk("rst_exp_y",     exp_y,         16'h0000);
    chk("rst_busy",      busy,          1'b0);
    chk("rst_err",       err_underflow, 1'b0);

    // Single exp on channel 2
    next_cycle();
    set_req(2, 1'b0, 16'h0000);
    mid();
    chk("p1_rdy", req_rdy, 4'b0100);
    expect_rsp(1'b0, 2, cyc, 16'h0000);
    next_cycle();
    req_v = '0;
    mid();
    chk("p1_busy", busy, 1'b1);
    repeat (LS + 4) next_cycle();
    check_logs("p1");

    // Single softplus on channel 0
    set_req(0, 1'b1, 16'h0000);
    mid();
    chk("p2_rdy", req_rdy, 4'b0001);
    expect_rsp(1'b1, 0, cyc, 16'h0000);
    next_cycle();
    req_v = '0;
    repeat (LS + 4) next_cycle();
    check_logs("p2");

    // Reset to bring ptr back to 0
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;

    // All channels request every cycle, modes alternating
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < NCH; c++)
        set_req(c, ((c + n[c]) % 2) == 1, 16'(c*256 + n[c]*17));
      mid();
      g = k % NCH;
      chk("p3_grant", req_rdy, 32'(1 << g));
      expect_rsp(((g + n[g]) % 2) == 1, g, cyc, 16'(g*256 + n[g]*17));
      n[g]++;
      next_cycle();
    end
    req_v = '0;
    repeat (LS + 4) next_cycle();
    check_logs("p3");

    // Fill the softplus FIFO from channel 1
    a0 = 0;
    for (int k = 0; k < 16; k++) begin
      set_req(1, 1'b1, 16'(16'h2000 + k));
      mid();
      if (k == 0) a0 = cyc;
      chk("p4_fill_rdy", req_rdy, 4'b0010);
      expect_rsp(1'b1, 1, cyc, 16'(16'h2000 + k));
      next_cycle();
    end
    set_req(1, 1'b1, 16'h2010);
    set_req(2, 1'b0, 16'h2100);
    mid();
    chk("p4_full_cycle", cyc, a0 + 16);
    chk("p4_full_blocks_sp_only", req_rdy, 4'b0100);
    expect_rsp(1'b0, 2, cyc, 16'h2100);
    next_cycle();
    req_v[2] = 1'b0;
    mid();
    chk("p4_pop_does_not_free_same_cycle", req_rdy, 4'b0000);
    chk("p4_first_sp_pop", sp_rsp_v, 4'b0010);
    next_cycle();
    mid();
    chk("p4_sp_regranted", req_rdy, 4'b0010);
    expect_rsp(1'b1, 1, cyc, 16'h2010);
    next_cycle();
    req_v = '0;
    repeat (LS + 4) next_cycle();
    check_logs("p4");

    // Softplus and exp completing in the same cycle
    set_req(3, 1'b1, 16'h0005);
    mid();
    chk("p5_sp_rdy", req_rdy, 4'b1000);
    expect_rsp(1'b1, 3, cyc, 16'h0005);
    next_cycle();
    req_v = '0;
    repeat (LS - LE - 1) next_cycle();
    set_req(1, 1'b0, 16'h0007);
    mid();
    chk("p5_exp_rdy", req_rdy, 4'b0010);
    expect_rsp(1'b0, 1, cyc, 16'h0007);
    next_cycle();
    req_v = '0;
    repeat (LE) next_cycle();
    mid();
    chk("p5_sp_rsp_v",  sp_rsp_v,  4'b1000);
    chk("p5_exp_rsp_v", exp_rsp_v, 4'b0010);
    chk("p5_sp_y",      sp_y,      16'h3989);
    chk("p5_exp_y",     exp_y,     16'h3C07);
    next_cycle();
    repeat (4) next_cycle();
    check_logs("p5");

    // Reset with five requests in flight
    for (int k = 0; k < 5; k++) begin
      set_req(k % NCH, (k % 2) == 1, 16'(16'h3000 + k));
      mid();
      chk("p6_rdy", req_rdy, 32'(1 << (k % NCH)));
      next_cycle();
      req_v = '0;
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    mid();
    chk("p6_req_rdy",   req_rdy,   4'b0000);
    chk("p6_sp_rsp_v",  sp_rsp_v,  4'b0000);
    chk("p6_exp_rsp_v", exp_rsp_v, 4'b0000);
    chk("p6_sp_y",      sp_y,      16'h0000);
    chk("p6_exp_y",     exp_y,     16'h0000);
    chk("p6_busy",      busy,      1'b0);
    next_cycle();
    repeat (LS + 6) next_cycle();
    check_logs("p6_flush");
    set_req(2, 1'b0, 16'h0010);
    mid();
    chk("p6_new_rdy", req_rdy, 4'b0100);
    expect_rsp(1'b0, 2, cyc, 16'h0010);
    next_cycle();
    req_v = '0;
    repeat (LS + 4) next_cycle();
    check_logs("p6_after");
    chk("p6_err_underflow", err_underflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
